// File: rtl/counter_seq_ctrl_pkg.sv
// Shared state encoding, default widths and accept-time next-state helper for counter_seq_ctrl.
// Pure declarations; no latency or backpressure of its own.
package counter_seq_ctrl_pkg;

  localparam int DEF_GAP_W = 8;
  localparam int DEF_NUM_W = 8;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_OVF_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAP   = 2'd1,
    ST_PULSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A zero-pulse burst completes immediately; a zero gap skips the idle phase.
  function automatic state_t accept_state(input logic num_zero, input logic gap_zero);
    if (num_zero) return ST_DONE;
    if (gap_zero) return ST_PULSE;
    return ST_GAP;
  endfunction

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Host-side control/status bundle for counter_seq_ctrl: burst request in, burst status out.
// Level/strobe signals only, no backpressure; status is registered inside the sequencer.
interface counter_seq_ctrl_if
  import counter_seq_ctrl_pkg::*;
#(
  parameter int GAP_W = DEF_GAP_W,
  parameter int NUM_W = DEF_NUM_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int OVF_W = DEF_OVF_W
) ();

  logic             start;
  logic             abort;
  logic [GAP_W-1:0] gap_len;
  logic [NUM_W-1:0] pulse_num;
  logic             busy;
  logic             done;
  logic [NUM_W-1:0] pulses_sent;
  logic [OVF_W-1:0] ovf_cnt;
  logic [CNT_W-1:0] final_q;

  modport master (
    output start, abort, gap_len, pulse_num,
    input  busy, done, pulses_sent, ovf_cnt, final_q
  );

  modport slave (
    input  start, abort, gap_len, pulse_num,
    output busy, done, pulses_sent, ovf_cnt, final_q
  );

endinterface

// File: rtl/counter_seq_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// One-cycle update latency; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Drives the counter IP enable as gap_len idle cycles then a one-cycle pulse, pulse_num times.
// First cin gap_len+1 cycles after start accept; start ignored while busy, abort returns to IDLE.
module counter_seq_ctrl
  import counter_seq_ctrl_pkg::*;
#(
  parameter int GAP_W = DEF_GAP_W,
  parameter int NUM_W = DEF_NUM_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int OVF_W = DEF_OVF_W
) (
  input  logic             clock,
  input  logic             rst_n,
  counter_seq_ctrl_if.slave ctrl,
  output logic             cin,
  input  logic             cout,
  input  logic [CNT_W-1:0] q
);

  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
  localparam logic [NUM_W-1:0] NUM_ONE = NUM_W'(1);

  state_t           state_r, state_nxt;
  logic [GAP_W-1:0] gap_len_r, gap_len_nxt;
  logic [GAP_W-1:0] gap_cnt_r, gap_cnt_nxt;
  logic [NUM_W-1:0] pulse_num_r, pulse_num_nxt;
  logic [NUM_W-1:0] sent_r, sent_nxt;
  logic             ovf_clr;
  logic             cin_r, busy_r, done_r;
  logic [CNT_W-1:0] final_q_r;
  logic [OVF_W-1:0] ovf_cnt;

  always_comb begin
    state_nxt     = state_r;
    gap_len_nxt   = gap_len_r;
    gap_cnt_nxt   = gap_cnt_r;
    pulse_num_nxt = pulse_num_r;
    sent_nxt      = sent_r;
    ovf_clr       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ctrl.start && !ctrl.abort) begin
          gap_len_nxt   = ctrl.gap_len;
          pulse_num_nxt = ctrl.pulse_num;
          gap_cnt_nxt   = '0;
          sent_nxt      = '0;
          ovf_clr       = 1'b1;
          state_nxt     = accept_state(ctrl.pulse_num == '0, ctrl.gap_len == '0);
        end
      end
      ST_GAP: begin
        if (ctrl.abort) begin
          state_nxt = ST_IDLE;
        end else if (gap_cnt_r == (gap_len_r - GAP_ONE)) begin
          state_nxt = ST_PULSE;
        end else begin
          gap_cnt_nxt = gap_cnt_r + GAP_ONE;
        end
      end
      ST_PULSE: begin
        // The pulse on the wire this cycle is counted even when aborting.
        sent_nxt = sent_r + NUM_ONE;
        if (ctrl.abort) begin
          state_nxt = ST_IDLE;
        end else if ((sent_r + NUM_ONE) == pulse_num_r) begin
          state_nxt = ST_DONE;
        end else if (gap_len_r == '0) begin
          state_nxt = ST_PULSE;
        end else begin
          gap_cnt_nxt = '0;
          state_nxt   = ST_GAP;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      gap_len_r   <= '0;
      gap_cnt_r   <= '0;
      pulse_num_r <= '0;
      sent_r      <= '0;
      cin_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      final_q_r   <= '0;
    end else begin
      state_r     <= state_nxt;
      gap_len_r   <= gap_len_nxt;
      gap_cnt_r   <= gap_cnt_nxt;
      pulse_num_r <= pulse_num_nxt;
      sent_r      <= sent_nxt;
      cin_r       <= (state_nxt == ST_PULSE);
      busy_r      <= (state_nxt == ST_GAP) || (state_nxt == ST_PULSE);
      done_r      <= (state_nxt == ST_DONE);
      if (state_r == ST_DONE) begin
        final_q_r <= q;
      end
    end
  end

  // Only an enabled cycle with carry-out is a real wrap of the counter IP.
  sat_counter #(.W(OVF_W)) u_ovf_cnt (
    .clock (clock),
    .rst_n (rst_n),
    .clr   (ovf_clr),
    .inc   (cin_r & cout),
    .cnt   (ovf_cnt)
  );

  assign cin              = cin_r;
  assign ctrl.busy        = busy_r;
  assign ctrl.done        = done_r;
  assign ctrl.pulses_sent = sent_r;
  assign ctrl.ovf_cnt     = ovf_cnt;
  assign ctrl.final_q     = final_q_r;

endmodule
